// File: rtl/cpu_pkg.sv
// Shared types and defaults for the accumulator datapath.
// Build with CPU_DATAPATH_ROTATE_EN to enable the ALU rotate/swap modes.
package cpu_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_RF_ADDR_WIDTH = 3;

   typedef enum logic [1:0] {
      SEL_IMM = 2'b00,
      SEL_RF  = 2'b01,
      SEL_ALU = 2'b10,
      SEL_IN  = 2'b11
   } acc_sel_e;

   typedef enum logic [1:0] {
      ROT_NONE  = 2'b00,
      ROT_LEFT  = 2'b01,
      ROT_RIGHT = 2'b10,
      ROT_SWAP  = 2'b11
   } rot_e;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_op_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control strobes in and data/flags out between control_unit and datapath.
// master = control side, slave = datapath side.
interface cpu_datapath_if
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH
);

   logic [DATA_WIDTH-1:0]    imm_data;
   logic [DATA_WIDTH-1:0]    data_in;
   logic [1:0]               mux_select;
   logic                     acc_enable;
   logic                     rf_write;
   logic [RF_ADDR_WIDTH-1:0] rf_address;
   logic                     alu_select;
   logic [1:0]               alu_rotate;
   logic                     output_enable;
   logic [DATA_WIDTH-1:0]    acc_out;
   logic [DATA_WIDTH-1:0]    out_data;
   logic                     out_valid;
   logic                     positive_flag;
   logic                     zero_flag;

   modport master (
      output imm_data, data_in, mux_select, acc_enable, rf_write,
      output rf_address, alu_select, alu_rotate, output_enable,
      input  acc_out, out_data, out_valid, positive_flag, zero_flag
   );

   modport slave (
      input  imm_data, data_in, mux_select, acc_enable, rf_write,
      input  rf_address, alu_select, alu_rotate, output_enable,
      output acc_out, out_data, out_valid, positive_flag, zero_flag
   );

endinterface

// File: rtl/cpu_alu.sv
// Combinational add/subtract ALU; rotate and nibble-swap modes exist only
// when CPU_DATAPATH_ROTATE_EN is defined.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0] operand,
   input  logic                  alu_select,
   input  logic [1:0]            alu_rotate,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int HALF = DATA_WIDTH / 2;

   logic [DATA_WIDTH-1:0] arith;

   assign arith = (alu_select == ALU_SUB) ? acc - operand
                                          : acc + operand;

`ifdef CPU_DATAPATH_ROTATE_EN
   always_comb begin
      result = arith;
      unique case (alu_rotate)
         ROT_NONE:  result = arith;
         ROT_LEFT:  result = {acc[DATA_WIDTH-2:0], acc[DATA_WIDTH-1]};
         ROT_RIGHT: result = {acc[0], acc[DATA_WIDTH-1:1]};
         ROT_SWAP:  result = {acc[HALF-1:0], acc[DATA_WIDTH-1:HALF]};
         default:   result = arith;
      endcase
   end
`else
   logic unused_rotate;

   assign unused_rotate = ^alu_rotate;
   assign result        = arith;
`endif

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator datapath: accumulator, 8-entry register file, output latch.
// CPU_DATAPATH_ROTATE_EN enables the ALU rotate modes (see cpu_alu).
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH
) (
   input logic            clock,
   input logic            reset,
   cpu_datapath_if.slave  bus
);

   localparam int DEPTH = 2 ** RF_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] rf [DEPTH];
   logic [DATA_WIDTH-1:0] rf_rd;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [DATA_WIDTH-1:0] out_q;
   logic                  valid_q;

   assign rf_rd = rf[bus.rf_address];

   cpu_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .acc        (acc),
      .operand    (rf_rd),
      .alu_select (bus.alu_select),
      .alu_rotate (bus.alu_rotate),
      .result     (alu_res)
   );

   always_comb begin
      acc_next = acc;
      unique case (bus.mux_select)
         SEL_IMM: acc_next = bus.imm_data;
         SEL_RF:  acc_next = rf_rd;
         SEL_ALU: acc_next = alu_res;
         SEL_IN:  acc_next = bus.data_in;
         default: acc_next = acc;
      endcase
   end

   // All writes sample the pre-edge accumulator and rf contents.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc     <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rf[i] <= '0;
         end
      end else begin
         if (bus.acc_enable) begin
            acc <= acc_next;
         end
         if (bus.rf_write) begin
            rf[bus.rf_address] <= acc;
         end
         if (bus.output_enable) begin
            out_q <= acc;
         end
         valid_q <= bus.output_enable;
      end
   end

   assign bus.acc_out       = acc;
   assign bus.out_data      = out_q;
   assign bus.out_valid     = valid_q;
   assign bus.zero_flag     = (acc == '0);
   assign bus.positive_flag = !acc[DATA_WIDTH-1] && (acc != '0);

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Accumulator-based execution datapath sitting directly downstream of `control_unit`. Each cycle it consumes that unit's control strobes, which select the accumulator source, the register-file writes, the ALU operation and rotation, and output loads. It holds the architectural data state: the accumulator, an 8-entry register file, and the output latch. It returns `positive_flag` and `zero_flag` for branch decisions.

## Interface
- `DATA_WIDTH`, 8, width of accumulator, register-file entries, ALU and I/O data.
- `RF_ADDR_WIDTH`, 3, register-file address width; depth = 2**RF_ADDR_WIDTH.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `imm_data` input DATA_WIDTH: immediate operand from the instruction.
- `data_in` input DATA_WIDTH: external user input (switches).
- `mux_select` input 2: accumulator source select.
- `acc_enable` input 1: load accumulator from selected source.
- `rf_write` input 1: write accumulator into `rf[rf_address]`.
- `rf_address` input RF_ADDR_WIDTH: register-file read/write index.
- `alu_select` input 1: 0 = add, 1 = subtract.
- `alu_rotate` input 2: ALU rotate mode.
- `output_enable` input 1: latch accumulator to output.
- `acc_out` output DATA_WIDTH: current accumulator value.
- `out_data` output DATA_WIDTH: output latch contents.
- `out_valid` output 1: one-cycle pulse after `out_data` is loaded.
- `positive_flag` output 1: accumulator signed-positive (MSB 0 and nonzero).
- `zero_flag` output 1: accumulator equals 0.

## Operation
- Accumulator source on `mux_select`:
  - 00: `imm_data`.
  - 01: `rf[rf_address]`.
  - 10: ALU result.
  - 11: `data_in`.
  - The accumulator loads only when `acc_enable` = 1; otherwise it holds.
- ALU is combinational:
  - Arithmetic result is `acc + rf[rf_address]` (alu_select 0) or `acc - rf[rf_address]` (alu_select 1), modulo 2**DATA_WIDTH. No carry or overflow is kept.
  - `alu_rotate` modes: 00 = arithmetic result; 01 = `acc` rotated left 1; 10 = `acc` rotated right 1; 11 = `acc` nibble swap (upper/lower halves exchanged).
- Register file: `rf_write` = 1 writes the current (pre-edge) accumulator into `rf[rf_address]`. Reads are asynchronous.
- Output: `output_enable` = 1 loads `out_data` with the pre-edge accumulator and sets `out_valid` = 1 for exactly the next cycle. `out_data` holds until the next load.
- Flags are combinational from the accumulator register. They therefore reflect a load in the same cycle `acc_out` changes.

## Timing
- Reset (async assert, sync release) values:
  - `acc_out` = 0, all rf entries = 0, `out_data` = 0, `out_valid` = 0.
  - `zero_flag` = 1, `positive_flag` = 0.
- Latency: any load is visible one cycle after the enabling edge. Flags follow in the same cycle as `acc_out`.
- Simultaneous events:
  - `acc_enable` + `rf_write`: the rf receives the old accumulator.
  - `rf_write` + `mux_select` = 01 on the same address: the accumulator receives the old rf contents.
  - `acc_enable` + `output_enable`: `out_data` receives the old accumulator.
  - `output_enable` on consecutive cycles: `out_valid` stays high, and `out_data` updates each cycle.
- Wrap-around: 0xFF + 0x01 → 0x00, with `zero_flag` = 1. 0x00 − 0x01 → 0xFF, with `positive_flag` = 0.
- Reset asserted mid-operation clears all state immediately. An in-flight `out_valid` pulse is cleared.

## Configuration
- `CPU_DATAPATH_ROTATE_EN` defined: `alu_rotate` decoded as above.
- `CPU_DATAPATH_ROTATE_EN` undefined: `alu_rotate` is ignored, and the ALU result is always the add/subtract result. The port remains present, unconnected internally.

## Structure
- Shared package `cpu_pkg`:
  - mux-select constants: `SEL_IMM`, `SEL_RF`, `SEL_ALU`, `SEL_IN`.
  - rotate codes: `ROT_NONE`, `ROT_LEFT`, `ROT_RIGHT`, `ROT_SWAP`.
  - ALU codes: `ALU_ADD`, `ALU_SUB`.
  - default `DATA_WIDTH` / `RF_ADDR_WIDTH`.
- One combinational sub-module, `cpu_alu`: operands, `alu_select` and `alu_rotate` in; result out. Rotate logic inside it is guarded by the macro.
- Accumulator, register file and output latch stay in `cpu_datapath`.

## Test plan
- Reset then idle → `acc_out` = 0x00, `zero_flag` = 1, `positive_flag` = 0, `out_valid` = 0, all rf reads 0x00.
- Load imm 0x05, rf_write r2, load imm 0x03, mux ALU add on r2 → `acc_out` = 0x08, `positive_flag` = 1.
- Load imm 0x00, ALU subtract with r1 = 0x01 → `acc_out` = 0xFF, `positive_flag` = 0, `zero_flag` = 0. Then load 0xFF and add with 0x01 → 0x00, `zero_flag` = 1.
- With macro defined and acc = 0x81, each test starting from 0x81:
  - rotate-left → 0x03.
  - rotate-right → 0xC0.
  - swap → 0x18.
  - Without macro, same stimulus with r0 = 0 → 0x81 (add result).
- acc = 0x2A, with `output_enable`, `acc_enable` (imm 0x11) and `rf_write` r4 in the same cycle → `out_data` = 0x2A, `rf[4]` = 0x2A, `acc_out` = 0x11, `out_valid` high for one cycle.
- Drive `reset` low mid-sequence with acc = 0x7E and `out_valid` high → all outputs return to reset values before the next clock edge.
